cpu_mem_responder: RTL and testbench

//  Responder side of the CPU instruction-fetch and load/store interfaces. Serves the

---
 rtl/cpu_mem_pkg.sv | 34 +++
 rtl/mem_dp_ram.sv | 27 ++
 rtl/cpu_mem_responder.sv | 102 ++++++++++
 tb/tb_cpu_mem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory responder: MMIO offsets, decode select, address decoder.
package cpu_mem_pkg;

  localparam logic [15:0] OFS_LEDR   = 16'h0000;
  localparam logic [15:0] OFS_CYCLES = 16'h0002;
  localparam logic [15:0] OFS_TIMER  = 16'h0004;
  localparam logic [15:0] OFS_STATUS = 16'h0006;

  typedef enum logic [2:0] {
    SEL_RAM,
    SEL_LEDR,
    SEL_CYCLES,
    SEL_TIMER,
    SEL_STATUS,
    SEL_NONE
  } addr_sel_e;

  // RAM takes priority; MMIO offsets are matched on word granularity (bit0 ignored).
  function automatic addr_sel_e decode_addr(input logic [15:0] addr,
                                            input logic [16:0] ram_bytes,
                                            input logic [15:0] mmio_base);
    logic [15:0] ofs;
    ofs = {addr[15:1], 1'b0} - mmio_base;
    if ({1'b0, addr} < ram_bytes) return SEL_RAM;
    case (ofs)
      OFS_LEDR:   return SEL_LEDR;
      OFS_CYCLES: return SEL_CYCLES;
      OFS_TIMER:  return SEL_TIMER;
      OFS_STATUS: return SEL_STATUS;
      default:    return SEL_NONE;
    endcase
  endfunction

endpackage

// File: rtl/mem_dp_ram.sv
// Dual-port word RAM: port A read-only, port B read/write, registered read-before-write outputs.
// Latency 1 cycle on both ports.
// No backpressure, writes always accepted.
module mem_dp_ram #(
  parameter int WORDS     = 4096,
  parameter     INIT_FILE = "",
  localparam int AW       = $clog2(WORDS)
) (
  input  logic          clk,
  input  logic [AW-1:0] a_addr,
  output logic [15:0]   a_rddata,
  input  logic [AW-1:0] b_addr,
  input  logic          b_we,
  input  logic [15:0]   b_wrdata,
  output logic [15:0]   b_rddata
);

  logic [15:0] mem [WORDS];

  // Non-blocking reads sample the old word, so a same-edge write is seen only next access.
  always_ff @(posedge clk) begin
    a_rddata <= mem[a_addr];
    b_rddata <= mem[b_addr];
    if (b_we) mem[b_addr] <= b_wrdata;
  end

endmodule

// File: rtl/cpu_mem_responder.sv
// Fetch and load/store responder: RAM plus LEDR/CYCLES/TIMER/STATUS MMIO bank.
// Read data returned 1 cycle after the address; no backpressure, stores never stall.
module cpu_mem_responder
  import cpu_mem_pkg::*;
#(
  parameter int          MEM_WORDS = 4096,
  parameter              INIT_FILE = "",
  parameter int          LEDR_W    = 10,
  parameter logic [15:0] MMIO_BASE = 16'h2000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [15:0]       i_pc_addr,
  output logic [15:0]       o_pc_rddata,
  input  logic [15:0]       i_ldst_addr,
  input  logic              i_ldst_rd,
  input  logic              i_ldst_wr,
  input  logic [15:0]       i_ldst_wrdata,
  output logic [15:0]       o_ldst_rddata,
  output logic [LEDR_W-1:0] o_ledr
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [16:0] RAM_BYTES = 17'(2 * MEM_WORDS);

  addr_sel_e         ldst_sel;
  addr_sel_e         sel_q;
  logic              pc_hit;
  logic              pc_hit_q;
  logic              ram_we;
  logic [15:0]       ram_a_q;
  logic [15:0]       ram_b_q;
  logic [LEDR_W-1:0] ledr_q;
  logic [15:0]       cycles_q;
  logic [15:0]       count_q;
  logic              expired_q;
  logic              ledr_wr;
  logic              timer_wr;
  logic              status_wr;
  logic              expire_evt;
  logic [15:0]       ldst_mux;

  assign ldst_sel   = decode_addr(i_ldst_addr, RAM_BYTES, MMIO_BASE);
  assign pc_hit     = {1'b0, i_pc_addr} < RAM_BYTES;
  assign ram_we     = i_ldst_wr && (ldst_sel == SEL_RAM) && !reset;
  assign ledr_wr    = i_ldst_wr && (ldst_sel == SEL_LEDR);
  assign timer_wr   = i_ldst_wr && (ldst_sel == SEL_TIMER);
  assign status_wr  = i_ldst_wr && (ldst_sel == SEL_STATUS);
  // A TIMER reload on the final count edge pre-empts the expiry.
  assign expire_evt = !timer_wr && (count_q == 16'd1);

  mem_dp_ram #(
    .WORDS     (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk      (clk),
    .a_addr   (i_pc_addr[AW:1]),
    .a_rddata (ram_a_q),
    .b_addr   (i_ldst_addr[AW:1]),
    .b_we     (ram_we),
    .b_wrdata (i_ldst_wrdata),
    .b_rddata (ram_b_q)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sel_q     <= SEL_NONE;
      pc_hit_q  <= 1'b0;
      ledr_q    <= '0;
      cycles_q  <= '0;
      count_q   <= '0;
      expired_q <= 1'b0;
    end else begin
      sel_q    <= i_ldst_rd ? ldst_sel : SEL_NONE;
      pc_hit_q <= pc_hit;
      cycles_q <= cycles_q + 16'd1;
      if (ledr_wr) ledr_q <= i_ldst_wrdata[LEDR_W-1:0];
      if (timer_wr)            count_q <= i_ldst_wrdata;
      else if (count_q != '0)  count_q <= count_q - 16'd1;
      // Expiry beats a same-cycle STATUS clear.
      if (expire_evt)          expired_q <= 1'b1;
      else if (status_wr)      expired_q <= 1'b0;
    end
  end

  always_comb begin
    ldst_mux = '0;
    case (sel_q)
      SEL_RAM:    ldst_mux = ram_b_q;
      SEL_LEDR:   ldst_mux[LEDR_W-1:0] = ledr_q;
      SEL_CYCLES: ldst_mux = cycles_q;
      SEL_TIMER:  ldst_mux = count_q;
      SEL_STATUS: ldst_mux[0] = expired_q;
      default:    ldst_mux = '0;
    endcase
  end

  assign o_ldst_rddata = ldst_mux;
  assign o_pc_rddata   = pc_hit_q ? ram_a_q : 16'h0000;
  assign o_ledr        = ledr_q;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench for cpu_mem_responder: RAM, MMIO bank, collisions, reset and counter wrap.
module tb_cpu_mem_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] i_pc_addr;
  logic [15:0] o_pc_rddata;
  logic [15:0] i_ldst_addr;
  logic        i_ldst_rd;
  logic        i_ldst_wr;
  logic [15:0] i_ldst_wrdata;
  logic [15:0] o_ldst_rddata;
  logic [9:0]  o_ledr;

  int total  = 0;
  int passed = 0;
  int fails  = 0;

  cpu_mem_responder #(
    .MEM_WORDS (4096),
    .INIT_FILE (""),
    .LEDR_W    (10),
    .MMIO_BASE (16'h2000)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .i_pc_addr     (i_pc_addr),
    .o_pc_rddata   (o_pc_rddata),
    .i_ldst_addr   (i_ldst_addr),
    .i_ldst_rd     (i_ldst_rd),
    .i_ldst_wr     (i_ldst_wr),
    .i_ldst_wrdata (i_ldst_wrdata),
    .o_ldst_rddata (o_ldst_rddata),
    .o_ledr        (o_ledr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] a, input logic [15:0] d);
    i_ldst_addr   = a;
    i_ldst_wrdata = d;
    i_ldst_wr     = 1'b1;
    i_ldst_rd     = 1'b0;
    tick();
    i_ldst_wr     = 1'b0;
  endtask

  task automatic load(input logic [15:0] a, input logic [15:0] exp, input string tag);
    i_ldst_addr = a;
    i_ldst_rd   = 1'b1;
    tick();
    chk(tag, o_ldst_rddata, exp);
    i_ldst_rd   = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    i_pc_addr     = 16'h0000;
    i_ldst_addr   = 16'h0000;
    i_ldst_rd     = 1'b0;
    i_ldst_wr     = 1'b0;
    i_ldst_wrdata = 16'h0000;
    tick();
    tick();
    chk("rst_pc", o_pc_rddata, 16'h0000);
    chk("rst_ldst", o_ldst_rddata, 16'h0000);
    chk("rst_ledr", {6'b0, o_ledr}, 16'h0000);
    reset = 1'b0;
    load(16'h2004, 16'h0000, "rst_timer");
    load(16'h2006, 16'h0000, "rst_status");

    // Store then load of a RAM word
    store(16'h0010, 16'hBEEF);
    load(16'h0010, 16'hBEEF, "ram_load");
    tick();
    chk("no_rd_zero", o_ldst_rddata, 16'h0000);

    // Fetch port, bit0 ignored, last RAM word, first non-RAM address
    store(16'h0000, 16'h1234);
    i_pc_addr = 16'h0000;
    tick();
    chk("fetch_w0", o_pc_rddata, 16'h1234);
    i_pc_addr = 16'h0001;
    tick();
    chk("fetch_bit0", o_pc_rddata, 16'h1234);
    store(16'h1FFE, 16'h7777);
    i_pc_addr = 16'h1FFE;
    tick();
    chk("fetch_last", o_pc_rddata, 16'h7777);
    i_pc_addr = 16'h2000;
    tick();
    chk("fetch_mmio_zero", o_pc_rddata, 16'h0000);
    load(16'h1FFF, 16'h7777, "load_bit0");

    // LEDR register and unmapped MMIO
    store(16'h2000, 16'h03FF);
    chk("ledr_out", {6'b0, o_ledr}, 16'h03FF);
    load(16'h2000, 16'h03FF, "ledr_read");
    load(16'h2008, 16'h0000, "unmapped_read");
    store(16'h2008, 16'hFFFF);
    chk("unmapped_wr_ledr", {6'b0, o_ledr}, 16'h03FF);
    store(16'h2000, 16'hFC01);
    load(16'h2000, 16'h0001, "ledr_trunc");

    // Timer countdown and sticky expiry
    store(16'h2004, 16'h0003);
    load(16'h2004, 16'h0002, "timer_2");
    load(16'h2004, 16'h0001, "timer_1");
    load(16'h2004, 16'h0000, "timer_0");
    load(16'h2006, 16'h0001, "status_set");
    load(16'h2004, 16'h0000, "timer_idle");
    store(16'h2006, 16'h0000);
    load(16'h2006, 16'h0000, "status_clr");

    // Expiry and STATUS clear on the same edge: set wins
    store(16'h2004, 16'h0001);
    store(16'h2006, 16'h0000);
    load(16'h2006, 16'h0001, "status_set_wins");
    store(16'h2006, 16'h1234);
    load(16'h2006, 16'h0000, "status_clr2");

    // Reload over a decrement, then reload with zero before expiry
    store(16'h2004, 16'h0005);
    store(16'h2004, 16'h0002);
    load(16'h2004, 16'h0001, "timer_reload");
    store(16'h2004, 16'h0000);
    load(16'h2006, 16'h0000, "timer_zero_no_exp");
    load(16'h2004, 16'h0000, "timer_zero_idle");

    // Same-cycle store with fetch and load of the same word
    store(16'h0020, 16'hAAAA);
    i_pc_addr     = 16'h0020;
    i_ldst_addr   = 16'h0020;
    i_ldst_wrdata = 16'h5555;
    i_ldst_wr     = 1'b1;
    i_ldst_rd     = 1'b1;
    tick();
    chk("rbw_load_old", o_ldst_rddata, 16'hAAAA);
    chk("rbw_fetch_old", o_pc_rddata, 16'hAAAA);
    i_ldst_wr = 1'b0;
    tick();
    chk("rbw_load_new", o_ldst_rddata, 16'h5555);
    chk("rbw_fetch_new", o_pc_rddata, 16'h5555);
    i_ldst_rd = 1'b0;

    // Reset in the middle of a timer run
    store(16'h0030, 16'h0F0F);
    store(16'h2000, 16'h002A);
    store(16'h2004, 16'd100);
    chk("ledr_2a", {6'b0, o_ledr}, 16'h002A);
    i_ldst_addr = 16'h2004;
    i_ldst_rd   = 1'b1;
    tick();
    chk("timer_99", o_ldst_rddata, 16'd99);
    tick();
    chk("timer_98", o_ldst_rddata, 16'd98);
    reset = 1'b1;
    #1;
    chk("mid_rst_ledr", {6'b0, o_ledr}, 16'h0000);
    chk("mid_rst_ldst", o_ldst_rddata, 16'h0000);
    chk("mid_rst_pc", o_pc_rddata, 16'h0000);
    i_ldst_rd     = 1'b0;
    i_ldst_addr   = 16'h0030;
    i_ldst_wrdata = 16'h1111;
    i_ldst_wr     = 1'b1;
    tick();
    i_ldst_wr = 1'b0;
    reset     = 1'b0;
    load(16'h2004, 16'h0000, "post_rst_timer");
    load(16'h2006, 16'h0000, "post_rst_status");
    i_ldst_addr = 16'h2002;
    i_ldst_rd   = 1'b1;
    tick();
    chk("cycles_3", o_ldst_rddata, 16'h0003);
    repeat (65532) tick();
    chk("cycles_ffff", o_ldst_rddata, 16'hFFFF);
    tick();
    chk("cycles_wrap", o_ldst_rddata, 16'h0000);
    i_ldst_rd = 1'b0;
    load(16'h0030, 16'h0F0F, "rst_edge_store_dropped");
    chk("post_rst_ledr", {6'b0, o_ledr}, 16'h0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
